apb_mem_slave: RTL and testbench
================================

Name: apb_mem_slave

Overview:
- Parametrised APB memory-mapped slave; next generation of the team's fixed 8-bit APB slaves.
- Adds configurable data/address width, memory depth and wait states.
- Registered read data, address-range error reporting (PSLVERR) and protocol-abort handling.
- Sits behind the APB master/decoder; one instance per PSEL line.

Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8, minimum 8.
- ADDR_W, 12, PADDR width in bits.
- DEPTH, 256, number of DATA_W-bit words in the memory.
- WAIT_STATES, 0, number of PREADY-low cycles inserted in every access phase; range 0..15.

Ports:
- PCLK  input  1  clock; all logic on the rising edge.
- PRESET  input  1  synchronous, active-high reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase strobe.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_W  byte address.
- PWDATA  input  DATA_W  write data.
- PRDATA  output  DATA_W  read data; registered.
- PREADY  output  1  transfer complete; registered.
- PSLVERR  output  1  error response; valid only while PREADY=1.

Behaviour:
- Single clock PCLK. Reset is synchronous and active-high on PRESET.
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, state=IDLE, wait counter=0. Memory contents are not reset.
- Address decode:
  - ADDR_LSB = log2(DATA_W/8).
  - Word index = PADDR[ADDR_W-1:ADDR_LSB]; low byte-offset bits are ignored.
  - Index >= DEPTH is out of range.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - On PSEL=1 and PENABLE=0 (setup phase): load cnt=WAIT_STATES.
  - If WAIT_STATES==0, go to READY; otherwise go to WAIT.
- WAIT:
  - While PSEL=1 and PENABLE=1, decrement cnt; go to READY on the edge where cnt==1.
  - PREADY stays 0 throughout WAIT.
- Entering READY (registered, same edge):
  - PREADY<=1.
  - PSLVERR<=out_of_range.
  - PRDATA<=mem[index] for an in-range read; 0 for a write or an out-of-range access.
- READY: PREADY=1 for exactly one cycle. At that edge:
  - In-range write: mem[index]<=PWDATA.
  - Out-of-range write: no memory update.
  - Then PREADY<=0, PSLVERR<=0, go to IDLE.
- Latency: PREADY rises on the (WAIT_STATES+1)-th cycle after the setup cycle. Zero-wait gives the standard 2-cycle APB transfer.
- Back-to-back transfers: a new setup phase in the cycle after READY is accepted; no idle cycle is required.
- PRDATA holds its value outside READY; only a read completion updates it.
- Protocol abort: PSEL drops in WAIT or READY → go to IDLE, PREADY<=0, no memory write.
- PENABLE=1 seen in IDLE without a preceding setup cycle: ignored; stay in IDLE, PREADY stays 0.
- Address and control must stay stable from setup through READY (APB rule). The slave samples PADDR/PWRITE/PWDATA at the READY edge.
- Reset mid-transfer: outputs go to reset values next edge; a pending write is discarded.

Optional Feature:
- Macro: APB_MEM_SLAVE_PSTRB_EN.
- When defined:
  - Adds input PSTRB, width DATA_W/8.
  - Writes update only the byte lanes whose strobe bit is 1.
  - PSTRB==0 on a write completes with PREADY=1, PSLVERR=0 and no memory change.
- When undefined: no PSTRB port; all byte lanes are written.
- Read behaviour is identical either way.

Decomposition:
- Package apb_mem_slave_pkg:
  - FSM state encoding (IDLE/WAIT/READY).
  - Function computing ADDR_LSB from DATA_W.
  - Maximum WAIT_STATES constant (15) and counter width (4).
- Sub-module apb_mem_slave_ram:
  - Synchronous-write, registered-read DATA_W x DEPTH array.
  - Per-byte write enable, driven all-ones when PSTRB is absent.
- The FSM, counter, decode and error logic stay in the top module.

Test Plan:
- Reset then zero-wait write 0xDEADBEEF @0x010, read @0x010 → PREADY high 2nd cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
- WAIT_STATES=3, read @0x004 → PREADY low 3 access cycles, high on 4th, then low next cycle.
- DEPTH=256, DATA_W=32, access @0x400 (index 256) → PREADY=1, PSLVERR=1, PRDATA=0; a subsequent read @0x000 shows unchanged data.
- PSEL dropped during WAIT of a write 0x12345678 @0x020 → no PREADY pulse, mem@0x020 unchanged; next full transfer completes normally.
- PRESET asserted mid-WAIT → next cycle PREADY=0, PSLVERR=0, PRDATA=0, state IDLE; pending write not committed.
- With APB_MEM_SLAVE_PSTRB_EN: mem@0x008=0x11223344, write 0xAABBCCDD with PSTRB=4'b0101 → read returns 0x11BB33DD.

Source files
------------

// File: rtl/apb_mem_slave_pkg.sv
// Shared constants for the parametrised APB memory slave: FSM state codes,
// wait-state limits and the byte-offset width helper.
package apb_mem_slave_pkg;

  // Wait-state counter sizing; WAIT_STATES above the maximum is clamped.
  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned CNT_W           = 4;

  // FSM state encoding, kept as plain constants for the legacy RTL that
  // still compares against raw state codes.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_READY = 2'd2;

  // Number of PADDR bits that select a byte inside one DATA_W-bit word.
  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_mem_slave_ram.sv
// DATA_W x DEPTH storage for the APB memory slave: synchronous write with
// per-byte enables and a registered read port that can also be cleared.
// Array contents are never reset; only the read register is.
module apb_mem_slave_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                rd_en,
  input  logic                rd_clr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write into the array.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read register: loaded on a read completion, cleared on any other
  // completion, otherwise holds its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB memory-mapped slave with configurable wait states,
// registered PRDATA/PREADY, PSLVERR for out-of-range word indices and
// abort handling when PSEL drops mid-transfer.
// Optional byte-strobe writes are enabled with `define APB_MEM_SLAVE_PSTRB_EN.
module apb_mem_slave
  import apb_mem_slave_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_MEM_SLAVE_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned LSB    = addr_lsb(DATA_W);
  localparam int unsigned IDX_W  = ADDR_W - LSB;
  localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WS_EFF = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES
                                                                   : WAIT_STATES;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   index;
  logic [RAM_AW-1:0]  ram_addr;
  logic               in_range;
  logic               setup;
  logic               access;
  logic               enter_ready;
  logic               wr_commit;
  logic               rd_load;
  logic               rd_clr;
  logic [LANES-1:0]   byte_en;

  // Word decode; byte-offset bits below LSB do not select anything.
  assign index    = PADDR[ADDR_W-1:LSB];
  assign ram_addr = RAM_AW'(index);
  assign in_range = (32'(index) < 32'(DEPTH));

  generate
    if (LSB > 0) begin : g_byte_off
      logic byte_off_unused;
      assign byte_off_unused = |PADDR[LSB-1:0];
    end
  endgenerate

`ifdef APB_MEM_SLAVE_PSTRB_EN
  assign byte_en = PSTRB;
`else
  assign byte_en = '1;
`endif

  // Phase decode and the one-edge events that drive the datapath.
  always_comb begin
    setup       = PSEL && !PENABLE;
    access      = PSEL && PENABLE;
    enter_ready = 1'b0;
    case (state)
      ST_IDLE: enter_ready = setup && (WS_EFF == 0);
      ST_WAIT: enter_ready = access && (cnt == CNT_W'(1));
      default: enter_ready = 1'b0;
    endcase
    // Write commits on the READY edge only if the transfer was not aborted.
    wr_commit = (state == ST_READY) && access && PWRITE && in_range;
    rd_load   = enter_ready && !PWRITE && in_range;
    rd_clr    = enter_ready && !rd_load;
  end

  // Transfer FSM, wait counter and registered handshake outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // PENABLE without a preceding setup cycle is not a setup phase.
          if (setup) begin
            cnt   <= CNT_W'(WS_EFF);
            state <= (WS_EFF == 0) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            state <= ST_IDLE;
          end else if (PENABLE) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= ST_READY;
            end
          end
        end
        ST_READY: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      // PREADY is a single-cycle pulse that coincides with the READY state;
      // PSLVERR is only ever raised alongside it.
      if (enter_ready) begin
        PREADY  <= 1'b1;
        PSLVERR <= !in_range;
      end else begin
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
      end
    end
  end

  apb_mem_slave_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk    (PCLK),
    .rst    (PRESET),
    .we     (wr_commit),
    .be     (byte_en),
    .addr   (ram_addr),
    .wdata  (PWDATA),
    .rd_en  (rd_load),
    .rd_clr (rd_clr),
    .rdata  (PRDATA)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: a zero-wait and a 3-wait-state
// instance share one APB bus (separate PSEL) and are checked against a
// word-array reference model built from the transfer rules.
module tb_apb_mem_slave;

  localparam int WS0 = 0;
  localparam int WS3 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel0, psel3, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int passed = 0;
  int total  = 0;

  // Reference memories: [0] = zero-wait instance, [1] = 3-wait instance.
  logic [31:0] mdl [2][256];

  always #5 clk = ~clk;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_STATES(WS0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_SLAVE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_STATES(WS3)) dut3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_SLAVE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3));

  function automatic int exp_lat(input int d);
    return (d == 0) ? WS0 + 1 : WS3 + 1;
  endfunction

  function automatic logic [3:0] rand_strb();
`ifdef APB_MEM_SLAVE_PSTRB_EN
    return 4'($urandom_range(0, 15));
`else
    return 4'hF;
`endif
  endfunction

  // Reference behaviour of one completed transfer.
  function automatic void model_apply(input int d, input bit wr, input logic [11:0] a,
                                      input logic [31:0] wd, input logic [3:0] s,
                                      output logic [31:0] exp_rd, output logic exp_err);
    int w;
    logic [31:0] mask;
    w       = int'(a) / 4;
    exp_err = (w >= 256);
    exp_rd  = '0;
    mask    = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (!exp_err) begin
      if (wr) mdl[d][w] = (mdl[d][w] & ~mask) | (wd & mask);
      else    exp_rd = mdl[d][w];
    end
  endfunction

  // Drives one transfer starting at a negedge; returns the access cycle on
  // which PREADY was seen (-1 aborted, -2 timeout) and PREADY one cycle later.
  task automatic do_xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input int abort_at, output int lat,
                         output logic [31:0] rd, output logic err, output logic rdy_after);
    psel0 = (d == 0); psel3 = (d == 1);
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = s;
    lat = -2; rd = '0; err = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (abort_at == c) begin
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        lat = -1;
        break;
      end
      if ((d == 0) ? pready0 : pready3) begin
        lat = c;
        rd  = (d == 0) ? prdata0 : prdata3;
        err = (d == 0) ? pslverr0 : pslverr3;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rdy_after = (d == 0) ? pready0 : pready3;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = 4'hF;
    repeat (3) @(negedge clk);
    total++; if (pready0 !== 1'b0)  $display("FAIL reset_pready0: got %b expected 0", pready0);   else passed++;
    total++; if (pslverr0 !== 1'b0) $display("FAIL reset_pslverr0: got %b expected 0", pslverr0); else passed++;
    total++; if (prdata0 !== 32'h0) $display("FAIL reset_prdata0: got %h expected 0", prdata0);   else passed++;
    total++; if (pready3 !== 1'b0)  $display("FAIL reset_pready3: got %b expected 0", pready3);   else passed++;
    total++; if (pslverr3 !== 1'b0) $display("FAIL reset_pslverr3: got %b expected 0", pslverr3); else passed++;
    total++; if (prdata3 !== 32'h0) $display("FAIL reset_prdata3: got %h expected 0", prdata3);   else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd, erd; logic err, eerr, ra;
    model_apply(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, erd, eerr);
    do_xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, lat, rd, err, ra);
    total++; if (lat !== 1)    $display("FAIL zw_wr_latency: got %0d expected 1", lat);  else passed++;
    total++; if (err !== eerr) $display("FAIL zw_wr_pslverr: got %b expected %b", err, eerr); else passed++;
    total++; if (ra !== 1'b0)  $display("FAIL zw_wr_pready_after: got %b expected 0", ra); else passed++;
    model_apply(0, 1'b0, 12'h010, '0, 4'hF, erd, eerr);
    do_xfer(0, 1'b0, 12'h010, '0, 4'hF, 0, lat, rd, err, ra);
    total++; if (lat !== 1)            $display("FAIL zw_rd_latency: got %0d expected 1", lat); else passed++;
    total++; if (rd !== 32'hDEADBEEF)  $display("FAIL zw_rd_data: got %h expected deadbeef", rd); else passed++;
    total++; if (rd !== erd)           $display("FAIL zw_rd_model: got %h expected %h", rd, erd); else passed++;
    total++; if (err !== 1'b0)         $display("FAIL zw_rd_pslverr: got %b expected 0", err); else passed++;
    total++; if (ra !== 1'b0)          $display("FAIL zw_rd_pready_after: got %b expected 0", ra); else passed++;
  endtask

  task automatic test_wait_states();
    int lat; logic [31:0] rd, erd, wd; logic err, eerr, ra;
    wd = $urandom() | 32'h1;
    model_apply(1, 1'b1, 12'h004, wd, 4'hF, erd, eerr);
    do_xfer(1, 1'b1, 12'h004, wd, 4'hF, 0, lat, rd, err, ra);
    total++; if (lat !== exp_lat(1)) $display("FAIL ws_wr_latency: got %0d expected %0d", lat, exp_lat(1)); else passed++;
    model_apply(1, 1'b0, 12'h004, '0, 4'hF, erd, eerr);
    do_xfer(1, 1'b0, 12'h004, '0, 4'hF, 0, lat, rd, err, ra);
    total++; if (lat !== exp_lat(1)) $display("FAIL ws_rd_latency: got %0d expected %0d", lat, exp_lat(1)); else passed++;
    total++; if (rd !== erd)         $display("FAIL ws_rd_data: got %h expected %h", rd, erd); else passed++;
    total++; if (err !== 1'b0)       $display("FAIL ws_rd_pslverr: got %b expected 0", err); else passed++;
    total++; if (ra !== 1'b0)        $display("FAIL ws_rd_pready_after: got %b expected 0", ra); else passed++;
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd, erd, wd; logic err, eerr, ra;
    for (int d = 0; d < 2; d++) begin
      wd = $urandom() | 32'h100;
      model_apply(d, 1'b1, 12'h000, wd, 4'hF, erd, eerr);
      do_xfer(d, 1'b1, 12'h000, wd, 4'hF, 0, lat, rd, err, ra);
      // Prime PRDATA with a nonzero read so the error completion must clear it.
      model_apply(d, 1'b0, 12'h000, '0, 4'hF, erd, eerr);
      do_xfer(d, 1'b0, 12'h000, '0, 4'hF, 0, lat, rd, err, ra);
      model_apply(d, 1'b0, 12'h400, '0, 4'hF, erd, eerr);
      do_xfer(d, 1'b0, 12'h400, '0, 4'hF, 0, lat, rd, err, ra);
      total++; if (lat !== exp_lat(d)) $display("FAIL oor_rd_latency[%0d]: got %0d expected %0d", d, lat, exp_lat(d)); else passed++;
      total++; if (err !== 1'b1)       $display("FAIL oor_rd_pslverr[%0d]: got %b expected 1", d, err); else passed++;
      total++; if (rd !== 32'h0)       $display("FAIL oor_rd_prdata[%0d]: got %h expected 0", d, rd); else passed++;
      total++; if (ra !== 1'b0)        $display("FAIL oor_pready_after[%0d]: got %b expected 0", d, ra); else passed++;
      model_apply(d, 1'b1, 12'h400, ~wd, 4'hF, erd, eerr);
      do_xfer(d, 1'b1, 12'h400, ~wd, 4'hF, 0, lat, rd, err, ra);
      total++; if (err !== 1'b1)       $display("FAIL oor_wr_pslverr[%0d]: got %b expected 1", d, err); else passed++;
      model_apply(d, 1'b0, 12'h000, '0, 4'hF, erd, eerr);
      do_xfer(d, 1'b0, 12'h000, '0, 4'hF, 0, lat, rd, err, ra);
      total++; if (rd !== erd)         $display("FAIL oor_word0_unchanged[%0d]: got %h expected %h", d, rd, erd); else passed++;
      total++; if (err !== 1'b0)       $display("FAIL oor_word0_pslverr[%0d]: got %b expected 0", d, err); else passed++;
    end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd, erd, k; logic err, eerr, ra;
    for (int d = 0; d < 2; d++) begin
      k = $urandom() | 32'h1;
      model_apply(d, 1'b1, 12'h020, k, 4'hF, erd, eerr);
      do_xfer(d, 1'b1, 12'h020, k, 4'hF, 0, lat, rd, err, ra);
      // Zero-wait aborts in READY, the wait-state instance aborts in WAIT.
      do_xfer(d, 1'b1, 12'h020, 32'h12345678, 4'hF, (d == 0) ? 1 : 2, lat, rd, err, ra);
      total++; if (lat !== -1)   $display("FAIL abort_no_pready[%0d]: got %0d expected -1", d, lat); else passed++;
      total++; if (ra !== 1'b0)  $display("FAIL abort_pready_after[%0d]: got %b expected 0", d, ra); else passed++;
      @(negedge clk);
      model_apply(d, 1'b0, 12'h020, '0, 4'hF, erd, eerr);
      do_xfer(d, 1'b0, 12'h020, '0, 4'hF, 0, lat, rd, err, ra);
      total++; if (rd !== erd)   $display("FAIL abort_mem_unchanged[%0d]: got %h expected %h", d, rd, erd); else passed++;
      model_apply(d, 1'b1, 12'h020, 32'h12345678, 4'hF, erd, eerr);
      do_xfer(d, 1'b1, 12'h020, 32'h12345678, 4'hF, 0, lat, rd, err, ra);
      total++; if (lat !== exp_lat(d)) $display("FAIL abort_next_latency[%0d]: got %0d expected %0d", d, lat, exp_lat(d)); else passed++;
      model_apply(d, 1'b0, 12'h020, '0, 4'hF, erd, eerr);
      do_xfer(d, 1'b0, 12'h020, '0, 4'hF, 0, lat, rd, err, ra);
      total++; if (rd !== 32'h12345678) $display("FAIL abort_next_data[%0d]: got %h expected 12345678", d, rd); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd, erd, k; logic err, eerr, ra;
    k = $urandom() | 32'h1;
    model_apply(1, 1'b1, 12'h030, k, 4'hF, erd, eerr);
    do_xfer(1, 1'b1, 12'h030, k, 4'hF, 0, lat, rd, err, ra);
    model_apply(1, 1'b0, 12'h030, '0, 4'hF, erd, eerr);
    do_xfer(1, 1'b0, 12'h030, '0, 4'hF, 0, lat, rd, err, ra);
    // Start a write, let one wait cycle elapse, then pulse reset.
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (pready3 !== 1'b0)  $display("FAIL rstmid_pready: got %b expected 0", pready3); else passed++;
    total++; if (pslverr3 !== 1'b0) $display("FAIL rstmid_pslverr: got %b expected 0", pslverr3); else passed++;
    total++; if (prdata3 !== 32'h0) $display("FAIL rstmid_prdata: got %h expected 0", prdata3); else passed++;
    rst = 1'b0;
    // Bus still shows an access phase, but the slave is back in IDLE.
    repeat (5) @(negedge clk);
    total++; if (pready3 !== 1'b0)  $display("FAIL rstmid_idle_pready: got %b expected 0", pready3); else passed++;
    psel3 = 1'b0; penable = 1'b0;
    @(negedge clk);
    model_apply(1, 1'b0, 12'h030, '0, 4'hF, erd, eerr);
    do_xfer(1, 1'b0, 12'h030, '0, 4'hF, 0, lat, rd, err, ra);
    total++; if (rd !== erd) $display("FAIL rstmid_write_discarded: got %h expected %h", rd, erd); else passed++;
  endtask

  task automatic test_penable_in_idle();
    int lat; logic [31:0] rd, erd, k; logic err, eerr, ra;
    k = $urandom();
    model_apply(0, 1'b1, 12'h040, k, 4'hF, erd, eerr);
    do_xfer(0, 1'b1, 12'h040, k, 4'hF, 0, lat, rd, err, ra);
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h040; pwdata = ~k; pstrb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (pready0 !== 1'b0) $display("FAIL idle_penable_pready[%0d]: got %b expected 0", c, pready0); else passed++;
    end
    psel0 = 1'b0; penable = 1'b0;
    @(negedge clk);
    model_apply(0, 1'b0, 12'h040, '0, 4'hF, erd, eerr);
    do_xfer(0, 1'b0, 12'h040, '0, 4'hF, 0, lat, rd, err, ra);
    total++; if (rd !== erd) $display("FAIL idle_penable_mem: got %h expected %h", rd, erd); else passed++;
  endtask

`ifdef APB_MEM_SLAVE_PSTRB_EN
  task automatic test_pstrb();
    int lat; logic [31:0] rd, erd; logic err, eerr, ra;
    model_apply(0, 1'b1, 12'h008, 32'h11223344, 4'hF, erd, eerr);
    do_xfer(0, 1'b1, 12'h008, 32'h11223344, 4'hF, 0, lat, rd, err, ra);
    model_apply(0, 1'b1, 12'h008, 32'hAABBCCDD, 4'b0101, erd, eerr);
    do_xfer(0, 1'b1, 12'h008, 32'hAABBCCDD, 4'b0101, 0, lat, rd, err, ra);
    model_apply(0, 1'b1, 12'h008, 32'hFFFFFFFF, 4'b0000, erd, eerr);
    do_xfer(0, 1'b1, 12'h008, 32'hFFFFFFFF, 4'b0000, 0, lat, rd, err, ra);
    total++; if (lat !== 1)    $display("FAIL strb0_latency: got %0d expected 1", lat); else passed++;
    total++; if (err !== 1'b0) $display("FAIL strb0_pslverr: got %b expected 0", err); else passed++;
    model_apply(0, 1'b0, 12'h008, '0, 4'hF, erd, eerr);
    do_xfer(0, 1'b0, 12'h008, '0, 4'hF, 0, lat, rd, err, ra);
    total++; if (rd !== 32'h11BB33DD) $display("FAIL strb_merge: got %h expected 11bb33dd", rd); else passed++;
  endtask
`endif

  task automatic test_random();
    int lat, d; bit wr; logic [11:0] a; logic [31:0] rd, erd, wd; logic [3:0] s; logic err, eerr, ra;
    for (int w = 0; w < 16; w++) begin
      for (int dd = 0; dd < 2; dd++) begin
        a = 12'h100 + 12'(w * 4);
        wd = $urandom();
        model_apply(dd, 1'b1, a, wd, 4'hF, erd, eerr);
        do_xfer(dd, 1'b1, a, wd, 4'hF, 0, lat, rd, err, ra);
        total++; if (lat !== exp_lat(dd)) $display("FAIL rnd_init_latency: got %0d expected %0d", lat, exp_lat(dd)); else passed++;
      end
    end
    for (int n = 0; n < 60; n++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 12'h400 + 12'($urandom_range(0, 255) * 4);
      else                           a = 12'h100 + 12'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      wd = $urandom();
      s  = rand_strb();
      model_apply(d, wr, a, wd, s, erd, eerr);
      do_xfer(d, wr, a, wd, s, 0, lat, rd, err, ra);
      total++; if (lat !== exp_lat(d)) $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, lat, exp_lat(d)); else passed++;
      total++; if (err !== eerr) $display("FAIL rnd_pslverr[%0d]: got %b expected %b", n, err, eerr); else passed++;
      total++; if (rd !== erd)   $display("FAIL rnd_prdata[%0d]: got %h expected %h", n, rd, erd); else passed++;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_penable_in_idle();
`ifdef APB_MEM_SLAVE_PSTRB_EN
    test_pstrb();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
